// File: rtl/fib_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_pkg: mode codes, FSM state encoding and seed constants shared by the  |
// | Fibonacci-class sequence generator.                  Revision: 1.0        |
// +--------------------------------------------------------------------------+
package fib_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] MODE_FIB    = 2'b00;
    localparam logic [1:0] MODE_LUCAS  = 2'b01;
    localparam logic [1:0] MODE_CUSTOM = 2'b10;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam int LUCAS_SEED_A = 2;
    localparam int LUCAS_SEED_B = 1;
    localparam int FIB_SEED_A   = 0;
    localparam int FIB_SEED_B   = 1;

endpackage
`default_nettype wire

// File: rtl/fib_seq_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_seq_gen_if: valid/ready term stream of the sequence generator.        |
// | Optional macro FIB_INDEX_EN adds the term_idx signal.  Revision: 1.0      |
// +--------------------------------------------------------------------------+
interface fib_seq_gen_if #(
    parameter int WIDTH = 8
`ifdef FIB_INDEX_EN
    , parameter int IDX_W = 8
`endif
) ();
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
`ifdef FIB_INDEX_EN
    logic [IDX_W-1:0] term_idx;
`endif

    modport master (
`ifdef FIB_INDEX_EN
        output term_idx,
`endif
        output out,
        output out_valid,
        input  out_ready
    );

    modport slave (
`ifdef FIB_INDEX_EN
        input  term_idx,
`endif
        input  out,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fib_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_tick_gen: modulo-DECIMATION cycle counter; tick marks the advancing   |
// | cycle at the terminal count.                          Revision: 1.0       |
// +--------------------------------------------------------------------------+
module fib_tick_gen #(
    parameter logic [19:0] DECIMATION = 20'd20
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    output logic      tick
);
    localparam logic [19:0] LAST = DECIMATION - 20'd1;

    logic [19:0] cnt_q;
    logic [19:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 20'd0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? 20'd0 : cnt_q + 20'd1;
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 20'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fib_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_seq_gen: rate-decimated Fibonacci/Lucas/custom sequence source with a |
// | valid/ready output. Optional macro FIB_INDEX_EN adds term_idx.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter logic [19:0] DECIMATION = 20'd20
`ifdef FIB_INDEX_EN
    , parameter int        IDX_W      = 8
`endif
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             stop,
    input  wire logic [1:0]       mode,
    input  wire logic             ovf_halt,
    input  wire logic [WIDTH-1:0] seed_a,
    input  wire logic [WIDTH-1:0] seed_b,
    fib_seq_gen_if.master         strm,
    output logic                  busy,
    output logic                  overflow
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             last_q, last_d;
    logic [WIDTH:0]   sum;
    logic             accept;
    logic             tick;
    logic             tick_en;
`ifdef FIB_INDEX_EN
    logic [IDX_W-1:0] term_idx_q, term_idx_d, next_idx_q, next_idx_d;
`endif

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign accept  = out_valid_q && strm.out_ready;
    // The counter freezes only while a presented term is being held off.
    assign tick_en = (state_q == ST_RUN) && !(out_valid_q && !strm.out_ready);

    fib_tick_gen #(.DECIMATION(DECIMATION)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == ST_LOAD),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        last_d      = last_q;
`ifdef FIB_INDEX_EN
        term_idx_d  = term_idx_q;
        next_idx_d  = next_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    case (mode)
                        MODE_LUCAS: begin
                            a_d = WIDTH'(LUCAS_SEED_A);
                            b_d = WIDTH'(LUCAS_SEED_B);
                        end
                        MODE_CUSTOM: begin
                            a_d = seed_a;
                            b_d = seed_b;
                        end
                        default: begin
                            a_d = WIDTH'(FIB_SEED_A);
                            b_d = WIDTH'(FIB_SEED_B);
                        end
                    endcase
                    overflow_d = 1'b0;
                    last_d     = 1'b0;
`ifdef FIB_INDEX_EN
                    term_idx_d = '0;
                    next_idx_d = '0;
`endif
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = tick | (out_valid_q & ~strm.out_ready);
                    if (accept) begin
                        a_d        = b_q;
                        b_d        = sum[WIDTH-1:0];
                        overflow_d = overflow_q | sum[WIDTH];
                        last_d     = sum[WIDTH] & ovf_halt;
`ifdef FIB_INDEX_EN
                        next_idx_d = next_idx_q + IDX_W'(1);
`endif
                    end
                    // A tick coinciding with an accept must present the successor term.
                    if (tick) begin
                        out_d = accept ? b_q : a_q;
`ifdef FIB_INDEX_EN
                        term_idx_d = accept ? next_idx_q + IDX_W'(1) : next_idx_q;
`endif
                    end
                    if (accept && last_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        out_d       = out_q;
`ifdef FIB_INDEX_EN
                        term_idx_d  = term_idx_q;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (stop)       state_d = ST_IDLE;
                else if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            last_q      <= 1'b0;
`ifdef FIB_INDEX_EN
            term_idx_q  <= '0;
            next_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            last_q      <= last_d;
`ifdef FIB_INDEX_EN
            term_idx_q  <= term_idx_d;
            next_idx_q  <= next_idx_d;
`endif
        end
    end

    assign strm.out       = out_q;
    assign strm.out_valid = out_valid_q;
`ifdef FIB_INDEX_EN
    assign strm.term_idx  = term_idx_q;
`endif
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign overflow       = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fib_seq_gen: directed vector bench for fib_seq_gen (DECIMATION 4 and   |
// | 1 instances). Honours FIB_INDEX_EN when defined.      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_fib_seq_gen;

    typedef struct {
        logic [1:0]       mode;
        logic             ovf;
        logic [7:0]       sa;
        logic [7:0]       sb;
        int               n;
        logic [0:15][7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       stop;
    logic       ovf_halt;
    logic [1:0] mode;
    logic [7:0] seed_a, seed_b;
    logic       start_a, start_b;
    logic       busy_a, busy_b, ovf_a, ovf_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef FIB_INDEX_EN
    fib_seq_gen_if #(.WIDTH(8), .IDX_W(8)) if_a ();
    fib_seq_gen_if #(.WIDTH(8), .IDX_W(8)) if_b ();
`else
    fib_seq_gen_if #(.WIDTH(8)) if_a ();
    fib_seq_gen_if #(.WIDTH(8)) if_b ();
`endif

    fib_seq_gen #(
        .WIDTH(8), .DECIMATION(20'd4)
`ifdef FIB_INDEX_EN
        , .IDX_W(8)
`endif
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop), .mode(mode),
        .ovf_halt(ovf_halt), .seed_a(seed_a), .seed_b(seed_b), .strm(if_a),
        .busy(busy_a), .overflow(ovf_a)
    );

    fib_seq_gen #(
        .WIDTH(8), .DECIMATION(20'd1)
`ifdef FIB_INDEX_EN
        , .IDX_W(8)
`endif
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop), .mode(mode),
        .ovf_halt(ovf_halt), .seed_a(seed_a), .seed_b(seed_b), .strm(if_b),
        .busy(busy_b), .overflow(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run_a(input logic [1:0] m, input logic o, input logic [7:0] sa,
                               input logic [7:0] sb);
        mode     = m;
        ovf_halt = o;
        seed_a   = sa;
        seed_b   = sb;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        step();
    endtask

    // Waits (bounded) for the next valid term and checks its spacing and value.
    task automatic get_term_a(input string name, input logic [7:0] exp, input int gap);
        int cyc;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!if_a.out_valid && cyc < 40);
        chk({name, "_gap"}, cyc, gap);
        chk(name, {24'd0, if_a.out}, {24'd0, exp});
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   held;
        int   seen;

        vecs[0] = '{mode: 2'b00, ovf: 1'b0, sa: 8'd0, sb: 8'd0, n: 8,
                    exp: {8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                          8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[1] = '{mode: 2'b01, ovf: 1'b0, sa: 8'd0, sb: 8'd0, n: 6,
                    exp: {8'd2, 8'd1, 8'd3, 8'd4, 8'd7, 8'd11, 8'd0, 8'd0,
                          8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[2] = '{mode: 2'b10, ovf: 1'b0, sa: 8'd5, sb: 8'd5, n: 5,
                    exp: {8'd5, 8'd5, 8'd10, 8'd15, 8'd25, 8'd0, 8'd0, 8'd0,
                          8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[3] = '{mode: 2'b11, ovf: 1'b0, sa: 8'd9, sb: 8'd9, n: 6,
                    exp: {8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd0, 8'd0,
                          8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[4] = '{mode: 2'b00, ovf: 1'b0, sa: 8'd0, sb: 8'd0, n: 16,
                    exp: {8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                          8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98}};

        reset = 1'b0; stop = 1'b0; ovf_halt = 1'b0; mode = 2'b00;
        seed_a = 8'd0; seed_b = 8'd0; start_a = 1'b0; start_b = 1'b0;
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        step();
        step();
        chk("rst_out", {24'd0, if_a.out}, 32'd0);
        chk("rst_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_overflow", {31'd0, ovf_a}, 32'd0);
        reset = 1'b1;
        step();

        // Table-driven runs with ready held high.
        for (int i = 0; i < 5; i++) begin
            start_run_a(vecs[i].mode, vecs[i].ovf, vecs[i].sa, vecs[i].sb);
            chk($sformatf("v%0d_busy", i), {31'd0, busy_a}, 32'd1);
            for (int t = 0; t < vecs[i].n; t++) begin
                get_term_a($sformatf("v%0d_t%0d", i, t), vecs[i].exp[t], 4);
                if (i == 4 && t == 12) chk("ovf_before_144", {31'd0, ovf_a}, 32'd0);
                if (i == 4 && t == 13) chk("ovf_after_144", {31'd0, ovf_a}, 32'd1);
            end
            pulse_stop();
            chk($sformatf("v%0d_stop_busy", i), {31'd0, busy_a}, 32'd0);
        end

        // Halt on overflow: last term 233, then DONE.
        start_run_a(2'b00, 1'b1, 8'd0, 8'd0);
        for (int t = 0; t < 14; t++) begin
            get_term_a($sformatf("halt_t%0d", t), vecs[4].exp[t], 4);
        end
        step();
        chk("done_busy", {31'd0, busy_a}, 32'd0);
        chk("done_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("done_out", {24'd0, if_a.out}, 32'd233);
        chk("done_overflow", {31'd0, ovf_a}, 32'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (if_a.out_valid) seen++;
        end
        chk("done_quiet", seen, 0);
        start_run_a(2'b01, 1'b0, 8'd0, 8'd0);
        get_term_a("restart_t0", 8'd2, 4);
        chk("restart_ovf_clr", {31'd0, ovf_a}, 32'd0);
        pulse_stop();

        // Backpressure on term 3, ignored start while busy, stop on term 8.
        start_run_a(2'b00, 1'b0, 8'd0, 8'd0);
        for (int t = 0; t < 5; t++) begin
            get_term_a($sformatf("bp_t%0d", t), vecs[0].exp[t], 4);
        end
        if_a.out_ready = 1'b0;
        held = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (if_a.out_valid && if_a.out == 8'd3) held++;
        end
        chk("bp_held", held, 10);
        if_a.out_ready = 1'b1;
        get_term_a("bp_next5", 8'd5, 4);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        get_term_a("busy_start_t8", 8'd8, 3);
        pulse_stop();
        chk("stop_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("stop_busy", {31'd0, busy_a}, 32'd0);
        chk("stop_out_held", {24'd0, if_a.out}, 32'd8);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (if_a.out_valid) seen++;
        end
        chk("stop_quiet", seen, 0);

        // Reset asserted mid-run.
        start_run_a(2'b00, 1'b0, 8'd0, 8'd0);
        for (int t = 0; t < 4; t++) begin
            get_term_a($sformatf("mr_t%0d", t), vecs[0].exp[t], 4);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mr_out", {24'd0, if_a.out}, 32'd0);
        chk("mr_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("mr_busy", {31'd0, busy_a}, 32'd0);

        // start and stop together from IDLE.
        start_a = 1'b1;
        stop    = 1'b1;
        step();
        start_a = 1'b0;
        stop    = 1'b0;
        step();
        chk("startstop_busy", {31'd0, busy_a}, 32'd0);

        // DECIMATION of 1: a new term every cycle.
        mode     = 2'b00;
        ovf_halt = 1'b0;
        start_b  = 1'b1;
        step();
        start_b  = 1'b0;
        step();
        step();
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("d1_valid%0d", t), {31'd0, if_b.out_valid}, 32'd1);
            chk($sformatf("d1_t%0d", t), {24'd0, if_b.out}, {24'd0, vecs[0].exp[t]});
`ifdef FIB_INDEX_EN
            chk($sformatf("d1_idx%0d", t), {24'd0, if_b.term_idx}, t);
`endif
            step();
        end
        pulse_stop();
        chk("d1_stop_busy", {31'd0, busy_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
